// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- receive-only 8N1 UART for the 6502 bus.
//
// Deserialises frames arriving on rxd_line, holds one received byte for the
// CPU and reports ready / overrun / framing-error status, with an optional
// active-low interrupt. Bus accesses are qualified by phi2; the CPU-visible
// side effects act on the synchronised phi2 falling edge.
//
// Ports
//   clk              system clock (10 MHz), the only clock domain
//   reset            synchronous, active-high reset
//   phi2             6502 phase-2 clock, asynchronous, synchronised here
//   enable           chip enable from the address decoder
//   register_select  0 = STATUS, 1 = DATA
//   rwb              1 = read, 0 = write
//   data_bus_r       CPU write data
//   data_bus_w       CPU read data (0 unless a read of this device)
//   rxd_line         serial input, idle high, asynchronous
//   irq_line         active-low interrupt request (registered)
//
// STATUS layout: {irq_enable, 4'b0, framing_error, overrun, rx_full}
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_DIVISOR = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phi2,
    input  logic       enable,
    input  logic       register_select,
    input  logic       rwb,
    input  logic [7:0] data_bus_r,
    output logic [7:0] data_bus_w,
    input  logic       rxd_line,
    output logic       irq_line
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_BREAK_WAIT = 3'd4
    } state_t;

    // Half a bit to reach the start-bit centre, then whole bits from there on.
    localparam logic [11:0] HALF_LOAD = 12'(CLK_DIVISOR / 2 - 1);
    localparam logic [11:0] FULL_LOAD = 12'(CLK_DIVISOR - 1);

    // Synchronisers and phi2 edge detection
    logic rxd_s1_q, rxd_s2_q;
    logic phi2_s1_q, phi2_s2_q, phi2_prev_q;
    logic phi2_fall_s;

    // Bus signals captured while phi2 is high
    logic en_q, rs_q, rwb_q;
    logic wr_irq_en_q, wr_clr_fe_q, wr_clr_ov_q;

    // Receiver datapath
    state_t      state_q, state_d;
    logic [11:0] bit_timer_q, bit_timer_d;
    logic [2:0]  bit_count_q, bit_count_d;
    logic [7:0]  shift_reg_q, shift_reg_d;
    logic        complete_s;
    logic        stop_bit_s;

    // CPU-visible registers
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_full_q, rx_full_d;
    logic       overrun_q, overrun_d;
    logic       framing_error_q, framing_error_d;
    logic       irq_enable_q, irq_enable_d;
    logic       irq_q;

    logic data_read_s;
    logic status_write_s;

    // Write-data bits that have no register behind them.
    logic unused_data_bits_s;
    assign unused_data_bits_s = ^{data_bus_r[6:3], data_bus_r[0]};

    assign phi2_fall_s    = phi2_prev_q & ~phi2_s2_q;
    assign data_read_s    = phi2_fall_s & en_q & rwb_q & rs_q;
    assign status_write_s = phi2_fall_s & en_q & ~rwb_q & ~rs_q;

    // Two-flop synchronisers for the asynchronous pins, plus phi2 edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1_q    <= 1'b1;
            rxd_s2_q    <= 1'b1;
            phi2_s1_q   <= 1'b0;
            phi2_s2_q   <= 1'b0;
            phi2_prev_q <= 1'b0;
        end else begin
            rxd_s1_q    <= rxd_line;
            rxd_s2_q    <= rxd_s1_q;
            phi2_s1_q   <= phi2;
            phi2_s2_q   <= phi2_s1_q;
            phi2_prev_q <= phi2_s2_q;
        end
    end

    // Capture the access qualifiers every clk while phi2 is high; the values
    // seen last before the fall are the ones that act.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            rwb_q       <= 1'b1;
            wr_irq_en_q <= 1'b0;
            wr_clr_fe_q <= 1'b0;
            wr_clr_ov_q <= 1'b0;
        end else if (phi2_s2_q) begin
            en_q        <= enable;
            rs_q        <= register_select;
            rwb_q       <= rwb;
            wr_irq_en_q <= data_bus_r[7];
            wr_clr_fe_q <= data_bus_r[2];
            wr_clr_ov_q <= data_bus_r[1];
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_timer_q <= 12'd0;
            bit_count_q <= 3'd0;
            shift_reg_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_timer_q <= bit_timer_d;
            bit_count_q <= bit_count_d;
            shift_reg_q <= shift_reg_d;
        end
    end

    // Receiver next-state: bit timing, sampling and frame completion
    always_comb begin
        state_d     = state_q;
        bit_timer_d = bit_timer_q;
        bit_count_d = bit_count_q;
        shift_reg_d = shift_reg_q;
        complete_s  = 1'b0;
        stop_bit_s  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s2_q) begin
                    bit_timer_d = HALF_LOAD;
                    state_d     = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_timer_q != 12'd0) begin
                    bit_timer_d = bit_timer_q - 12'd1;
                end else if (rxd_s2_q) begin
                    // Line went back high before the start-bit centre: glitch.
                    state_d = ST_IDLE;
                end else begin
                    bit_timer_d = FULL_LOAD;
                    bit_count_d = 3'd0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_timer_q != 12'd0) begin
                    bit_timer_d = bit_timer_q - 12'd1;
                end else begin
                    // LSB arrives first, so shift in from the top.
                    shift_reg_d = {rxd_s2_q, shift_reg_q[7:1]};
                    bit_timer_d = FULL_LOAD;
                    if (bit_count_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_count_d = bit_count_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_timer_q != 12'd0) begin
                    bit_timer_d = bit_timer_q - 12'd1;
                end else begin
                    complete_s = 1'b1;
                    stop_bit_s = rxd_s2_q;
                    if (rxd_s2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK_WAIT;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                if (rxd_s2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status/data register updates; a completing byte beats any clear that
    // lands in the same clk.
    always_comb begin
        rx_data_d       = rx_data_q;
        rx_full_d       = rx_full_q;
        overrun_d       = overrun_q;
        framing_error_d = framing_error_q;
        irq_enable_d    = irq_enable_q;

        if (data_read_s) begin
            rx_full_d = 1'b0;
            overrun_d = 1'b0;
        end else begin
            rx_full_d = rx_full_q;
        end

        if (status_write_s) begin
            irq_enable_d = wr_irq_en_q;
            if (wr_clr_fe_q) begin
                framing_error_d = 1'b0;
            end else begin
                framing_error_d = framing_error_q;
            end
            if (wr_clr_ov_q) begin
                overrun_d = 1'b0;
            end else begin
                overrun_d = overrun_d;
            end
        end else begin
            irq_enable_d = irq_enable_q;
        end

        if (complete_s) begin
            if (!rx_full_q || data_read_s) begin
                rx_data_d = shift_reg_q;
                rx_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
            if (!stop_bit_s) begin
                framing_error_d = 1'b1;
            end else begin
                framing_error_d = framing_error_d;
            end
        end else begin
            rx_data_d = rx_data_q;
        end
    end

    // CPU-visible registers and the registered interrupt output
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q       <= 8'd0;
            rx_full_q       <= 1'b0;
            overrun_q       <= 1'b0;
            framing_error_q <= 1'b0;
            irq_enable_q    <= 1'b0;
            irq_q           <= 1'b1;
        end else begin
            rx_data_q       <= rx_data_d;
            rx_full_q       <= rx_full_d;
            overrun_q       <= overrun_d;
            framing_error_q <= framing_error_d;
            irq_enable_q    <= irq_enable_d;
            irq_q           <= ~(irq_enable_q & (rx_full_q | overrun_q | framing_error_q));
        end
    end

    assign irq_line = irq_q;

    // Read mux: drive the bus only during a read of this device
    always_comb begin
        data_bus_w = 8'd0;
        if (enable && rwb) begin
            if (register_select) begin
                data_bus_w = rx_data_q;
            end else begin
                data_bus_w = {irq_enable_q, 4'b0000, framing_error_q, overrun_q, rx_full_q};
            end
        end else begin
            data_bus_w = 8'd0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx with CLK_DIVISOR = 8.
// Inputs are driven and outputs sampled on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       phi2;
    logic       enable;
    logic       register_select;
    logic       rwb;
    logic [7:0] data_bus_r;
    logic [7:0] data_bus_w;
    logic       rxd_line;
    logic       irq_line;

    int vectors     = 0;
    int miscompares = 0;

    uart_rx #(.CLK_DIVISOR(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .phi2            (phi2),
        .enable          (enable),
        .register_select (register_select),
        .rwb             (rwb),
        .data_bus_r      (data_bus_r),
        .data_bus_w      (data_bus_w),
        .rxd_line        (rxd_line),
        .irq_line        (irq_line)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One phi2 cycle: 4 clk high with the access presented, 4 clk low with
    // the qualifiers still held so the synchronised fall sees them.
    task automatic bus_access(input logic rs, input logic rw, input logic [7:0] wd,
                              output logic [7:0] rd);
        @(negedge clk);
        enable = 1'b1; register_select = rs; rwb = rw; data_bus_r = wd; phi2 = 1'b1;
        repeat (4) @(negedge clk);
        rd   = data_bus_w;
        phi2 = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b0; register_select = 1'b0; rwb = 1'b1; data_bus_r = 8'd0;
    endtask

    // Must be called at a falling clk edge; 8 clk per bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_clks);
        rxd_line = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_line = b[i];
            repeat (8) @(negedge clk);
        end
        rxd_line = stop;
        repeat (stop_clks) @(negedge clk);
        rxd_line = 1'b1;
    endtask

    task automatic read_check(input logic rs, input string tag, input logic [7:0] exp);
        logic [7:0] rd;
        bus_access(rs, 1'b1, 8'd0, rd);
        check(tag, rd, exp);
    endtask

    task automatic write_reg(input logic [7:0] wd);
        logic [7:0] rd;
        bus_access(1'b0, 1'b0, wd, rd);
    endtask

    initial begin
        int         cyc;
        logic [7:0] rd_sim;

        reset = 1'b1; phi2 = 1'b0; enable = 1'b0; register_select = 1'b0;
        rwb = 1'b1; data_bus_r = 8'd0; rxd_line = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_irq", {7'd0, irq_line}, 8'h01);
        check("rst_bus_idle", data_bus_w, 8'h00);
        read_check(1'b0, "rst_status", 8'h00);
        read_check(1'b1, "rst_data", 8'h00);

        // Basic receive
        @(negedge clk);
        send_byte(8'h41, 1'b1, 8);
        repeat (4) @(negedge clk);
        check("basic_bus_idle", data_bus_w, 8'h00);
        read_check(1'b0, "basic_status", 8'h01);
        read_check(1'b1, "basic_data", 8'h41);
        read_check(1'b0, "basic_status_after", 8'h00);

        // Overrun: two bytes back to back, no read between
        @(negedge clk);
        send_byte(8'h55, 1'b1, 8);
        send_byte(8'hAA, 1'b1, 8);
        repeat (4) @(negedge clk);
        read_check(1'b0, "ovr_status", 8'h03);
        read_check(1'b1, "ovr_data", 8'h55);
        read_check(1'b0, "ovr_status_after", 8'h00);

        // Framing error followed by a held break
        @(negedge clk);
        send_byte(8'h7F, 1'b0, 30);
        repeat (4) @(negedge clk);
        read_check(1'b0, "fe_status", 8'h05);
        read_check(1'b1, "fe_data", 8'h7F);
        read_check(1'b0, "fe_status_keep", 8'h04);
        write_reg(8'h04);
        read_check(1'b0, "fe_status_clr", 8'h00);
        @(negedge clk);
        send_byte(8'h12, 1'b1, 8);
        repeat (4) @(negedge clk);
        read_check(1'b0, "after_break_status", 8'h01);
        read_check(1'b1, "after_break_data", 8'h12);

        // False start: 2 clk glitch low
        @(negedge clk);
        rxd_line = 1'b0;
        repeat (2) @(negedge clk);
        rxd_line = 1'b1;
        repeat (100) @(negedge clk);
        read_check(1'b0, "false_start_status", 8'h00);

        // Interrupt enable and receive latency
        write_reg(8'h80);
        check("irq_idle", {7'd0, irq_line}, 8'h01);
        read_check(1'b0, "irq_en_status", 8'h80);
        @(negedge clk);
        cyc = 0;
        fork
            send_byte(8'h33, 1'b1, 8);
            begin
                while (irq_line === 1'b1 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        check("irq_latency_ok", {7'd0, (cyc >= 76 && cyc <= 84) ? 1'b1 : 1'b0}, 8'h01);
        check("irq_asserted", {7'd0, irq_line}, 8'h00);
        read_check(1'b1, "irq_data", 8'h33);
        check("irq_released", {7'd0, irq_line}, 8'h01);
        write_reg(8'h00);

        // DATA-read clear coinciding with the completion clk of the next byte
        @(negedge clk);
        send_byte(8'h5A, 1'b1, 8);
        repeat (4) @(negedge clk);
        fork
            send_byte(8'h3C, 1'b1, 8);
            begin
                repeat (71) @(negedge clk);
                bus_access(1'b1, 1'b1, 8'd0, rd_sim);
            end
        join
        check("sim_old_data", rd_sim, 8'h5A);
        repeat (4) @(negedge clk);
        read_check(1'b0, "sim_status", 8'h01);
        read_check(1'b1, "sim_new_data", 8'h3C);
        read_check(1'b0, "sim_status_after", 8'h00);

        // Reset mid-frame with a pending byte and interrupt asserted
        write_reg(8'h80);
        @(negedge clk);
        send_byte(8'h66, 1'b1, 8);
        repeat (4) @(negedge clk);
        check("pre_reset_irq", {7'd0, irq_line}, 8'h00);
        fork
            send_byte(8'hFF, 1'b1, 8);
            begin
                repeat (30) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("reset_irq", {7'd0, irq_line}, 8'h01);
            end
        join
        repeat (20) @(negedge clk);
        read_check(1'b0, "reset_status", 8'h00);
        read_check(1'b1, "reset_data", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
